vga_frame_scheduler: RTL and testbench

Sequences the raster for the demo core: a pixel-clock-enable divider, horizontal/vertical counters, registered sync/active/coordinate outputs, and frame/line strobes, all from the 48 MHz board clock. Start/stop is gated to frame boundaries by a small state machine, so a stop request always finishes the frame in progress. An optional line-rate audio sample tick is also provided. Sits between the board top and the effect/audio datapath.

---
 rtl/vga_frame_scheduler.sv | 158 +++++++++++++++
 tb/tb_vga_frame_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_scheduler.sv
// vga_frame_scheduler: raster sequencer for the demo core.
// Produces a pixel-clock-enable divider, h/v counters and registered
// sync/active/coordinate outputs from clk48. Start and stop take effect only
// at frame boundaries, so a stop always lets the frame in progress finish.
// Optional feature macro: VGA_FRAME_SCHEDULER_AUDIO_TICK_EN adds a line-rate
// audio sample strobe. Without it, audio_tick is tied low.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | raster halted, counters at 0, outputs at reset levels
// RUN       | raster running, end of frame wraps to (0,0)
// STOP_PEND | stop requested, finish the current frame and then go to IDLE
module vga_frame_scheduler #(
  parameter int PIX_DIV   = 2,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_NEG = 1'b1,
  parameter bit VSYNC_NEG = 1'b1,
  parameter int FC_W      = 16
) (
  input  logic            clk48,
  input  logic            rst_n,
  input  logic            run,
  output logic            hsync,
  output logic            vsync,
  output logic            active,
  output logic [10:0]     x,
  output logic [9:0]      y,
  output logic            line_start,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_count,
  output logic            audio_tick,
  output logic            running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [10:0]   H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0]   H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0]   HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0]   HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]    VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]    VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div;
  logic [10:0]   h;
  logic [9:0]    v;
  logic          pix_ce, eol, eof;

  assign pix_ce  = (state != IDLE) && (div == DIV_LAST);
  assign eol     = pix_ce && (h == H_LAST);
  assign eof     = eol && (v == V_LAST);
  assign running = (state != IDLE);

  // State register.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: run decides at every edge; end of frame chooses IDLE over STOP_PEND.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:          if (run) state_nxt = RUN;
      RUN, STOP_PEND: begin
        if (run)      state_nxt = RUN;
        else if (eof) state_nxt = IDLE;
        else          state_nxt = STOP_PEND;
      end
      default:       state_nxt = IDLE;
    endcase
  end

  // Pixel divider and raster counters. They are held at 0 while idle.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else if (state == IDLE) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else begin
      div <= pix_ce ? '0 : div + DW'(1);
      if (pix_ce) begin
        if (eol) begin
          h <= '0;
          v <= eof ? '0 : v + 10'd1;
        end else begin
          h <= h + 11'd1;
        end
      end
    end
  end

  // Completed-frame counter. It counts the last frame before IDLE and is retained while idle.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n)   frame_count <= '0;
    else if (eof) frame_count <= frame_count + FC_W'(1);
  end

  // Registered raster outputs, one clk behind the counters.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= HSYNC_NEG;
      vsync       <= VSYNC_NEG;
      active      <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (state == IDLE) begin
      hsync       <= HSYNC_NEG;
      vsync       <= VSYNC_NEG;
      active      <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= ((h >= HS_BEG) && (h < HS_END)) ^ HSYNC_NEG;
      vsync       <= ((v >= VS_BEG) && (v < VS_END)) ^ VSYNC_NEG;
      active      <= (h < H_ACT) && (v < V_ACT);
      x           <= h;
      y           <= v;
      line_start  <= (h == 11'd0) && (div == '0);
      frame_start <= (h == 11'd0) && (v == 10'd0) && (div == '0);
    end
  end

`ifdef VGA_FRAME_SCHEDULER_AUDIO_TICK_EN
  // One audio sample per line, aligned with line_start.
  assign audio_tick = line_start;
`else
  assign audio_tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Testbench for vga_frame_scheduler using small raster parameters.
// The reference model tracks the position in the frame as a clock count and
// derives h, v and the strobes from it arithmetically.
module tb_vga_frame_scheduler;

  localparam int PD = 2;
  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int LINE_CLKS  = PD * HT;
  localparam int FRAME_CLKS = LINE_CLKS * VT;
  localparam int FCW = 4;

  logic           clk48 = 1'b0;
  logic           rst_n = 1'b0;
  logic           run   = 1'b0;
  logic           hsync, vsync, active, line_start, frame_start, audio_tick, running;
  logic [10:0]    x;
  logic [9:0]     y;
  logic [FCW-1:0] frame_count;

  vga_frame_scheduler #(
    .PIX_DIV(PD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_NEG(1'b1), .VSYNC_NEG(1'b1), .FC_W(FCW)
  ) dut (
    .clk48(clk48), .rst_n(rst_n), .run(run),
    .hsync(hsync), .vsync(vsync), .active(active), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start),
    .frame_count(frame_count), .audio_tick(audio_tick), .running(running)
  );

  always #5 clk48 = ~clk48;

  int n_vec = 0;
  int n_err = 0;

  // model state
  bit m_run = 0;
  int m_pos = 0;
  int m_fc  = 0;
  int e_hs, e_vs, e_act, e_x, e_y, e_ls, e_fs, e_at;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_idle_outputs();
    e_hs = 1; e_vs = 1; e_act = 0; e_x = 0; e_y = 0; e_ls = 0; e_fs = 0;
  endtask

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_fc = 0;
    model_idle_outputs();
  endtask

  task automatic model_edge();
    int hh, vv;
    if (!m_run) begin
      model_idle_outputs();
      if (run) begin
        m_run = 1;
        m_pos = 0;
      end
    end else begin
      hh    = (m_pos / PD) % HT;
      vv    = m_pos / LINE_CLKS;
      e_act = (hh < HA && vv < VA) ? 1 : 0;
      e_hs  = (hh >= HA + HF && hh < HA + HF + HS) ? 0 : 1;
      e_vs  = (vv >= VA + VF && vv < VA + VF + VS) ? 0 : 1;
      e_x   = hh;
      e_y   = vv;
      e_ls  = (m_pos % LINE_CLKS == 0) ? 1 : 0;
      e_fs  = (m_pos == 0) ? 1 : 0;
      if (m_pos == FRAME_CLKS - 1) begin
        m_fc  = (m_fc + 1) % (1 << FCW);
        m_pos = 0;
        if (!run) m_run = 0;
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic compare_all();
`ifdef VGA_FRAME_SCHEDULER_AUDIO_TICK_EN
    e_at = e_ls;
`else
    e_at = 0;
`endif
    chk("hsync",       int'(hsync),       e_hs);
    chk("vsync",       int'(vsync),       e_vs);
    chk("active",      int'(active),      e_act);
    chk("x",           int'(x),           e_x);
    chk("y",           int'(y),           e_y);
    chk("line_start",  int'(line_start),  e_ls);
    chk("frame_start", int'(frame_start), e_fs);
    chk("frame_count", int'(frame_count), m_fc);
    chk("audio_tick",  int'(audio_tick),  e_at);
    chk("running",     int'(running),     int'(m_run));
  endtask

  // One clk: model samples run at the posedge, outputs are checked at the negedge.
  task automatic cycle();
    @(posedge clk48);
    if (!rst_n) model_reset();
    else        model_edge();
    @(negedge clk48);
    compare_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Advance until the model reaches line v while running.
  task automatic wait_line(input string tag, input int line);
    int k = 0;
    while (!(m_run && (m_pos / LINE_CLKS) == line) && k < 4 * FRAME_CLKS) begin
      cycle();
      k++;
    end
    chk(tag, (m_run && (m_pos / LINE_CLKS) == line) ? 1 : 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (m_run && k < 4 * FRAME_CLKS) begin
      cycle();
      k++;
    end
    chk(tag, int'(m_run), 0);
  endtask

  initial begin
    model_reset();
    @(negedge clk48);
    compare_all();
    cycles(3);
    rst_n = 1'b1;
    cycles(3);

    // continuous raster
    run = 1'b1;
    cycles(2 * FRAME_CLKS + 5);

    // stop requested in line 1, frame completes
    wait_line("wait_v1_stop", 1);
    run = 1'b0;
    wait_idle("wait_idle_stop");
    cycles(20);

    // stop request withdrawn before end of frame
    run = 1'b1;
    cycles(10);
    wait_line("wait_v1_cancel", 1);
    run = 1'b0;
    wait_line("wait_v3_cancel", 3);
    run = 1'b1;
    cycles(2 * FRAME_CLKS);

    // randomized run activity
    for (int s = 0; s < 40; s++) begin
      run = ($urandom_range(0, 3) != 0);
      cycles($urandom_range(1, 150));
    end
    run = 1'b1;
    cycles(FRAME_CLKS + 7);

    // asynchronous reset in the middle of a line, at h=2
    begin
      int k = 0;
      while (!(m_run && ((m_pos / PD) % HT) == 2) && k < 4 * FRAME_CLKS) begin
        cycle();
        k++;
      end
      chk("wait_h2", (m_run && ((m_pos / PD) % HT) == 2) ? 1 : 0, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk48);
    cycles(2);
    rst_n = 1'b1;
    cycles(FRAME_CLKS);

    // 17 frames to wrap frame_count
    cycles(17 * FRAME_CLKS);

    run = 1'b0;
    wait_idle("wait_idle_end");
    cycles(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
